// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures one byte per rx_end pulse into a small FIFO
// and exposes DATA / CTRL-STATUS registers plus a level interrupt to the CPU.
module uart_rx_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_end,
    output logic       rx_en,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ARMED, PUSH, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic           enable_reg, enable_next;
    logic           irq_en_reg, irq_en_next;
    logic           overrun_reg, overrun_next;
    logic           rx_end_prev_reg;
    logic           rx_en_reg;
    logic           irq_reg, irq_next;
    logic [7:0]     rdata_reg;
    logic [AW-1:0]  head_reg, head_next;
    logic [AW-1:0]  tail_reg, tail_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [7:0]     mem [DEPTH];

    logic ctrl_wr, data_rd, stat_rd;
    logic empty, full, push, pop, push_ok, ovr_set;

    assign ctrl_wr = cs & we & addr;
    assign data_rd = cs & ~we & ~addr;
    assign stat_rd = cs & ~we & addr;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    // A push whose enable was just cleared is discarded.
    assign push    = (state_reg == PUSH) & enable_reg;
    assign pop     = data_rd & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        enable_next  = ctrl_wr ? wdata[0] : enable_reg;
        irq_en_next  = ctrl_wr ? wdata[1] : irq_en_reg;
        overrun_next = ovr_set | (overrun_reg & ~(ctrl_wr & wdata[7]));
        head_next    = pop ? head_reg + AW'(1) : head_reg;
        tail_next    = push_ok ? tail_reg + AW'(1) : tail_reg;
        count_next   = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push_ok)
            count_next = count_reg - CW'(1);
        irq_next     = irq_en_next & ((count_next != '0) | overrun_next);
    end

    always_comb begin
        state_next = state_reg;
        if (!enable_reg) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = ARMED;
                ARMED:   if (rx_end && !rx_end_prev_reg) state_next = PUSH;
                PUSH:    state_next = DRAIN;
                DRAIN:   if (!rx_end) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            enable_reg      <= 1'b0;
            irq_en_reg      <= 1'b0;
            overrun_reg     <= 1'b0;
            rx_end_prev_reg <= 1'b0;
            rx_en_reg       <= 1'b0;
            irq_reg         <= 1'b0;
            rdata_reg       <= 8'h00;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            enable_reg      <= enable_next;
            irq_en_reg      <= irq_en_next;
            overrun_reg     <= overrun_next;
            rx_end_prev_reg <= rx_end;
            rx_en_reg       <= enable_next;
            irq_reg         <= irq_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            if (data_rd)
                rdata_reg <= empty ? 8'h00 : mem[head_reg];
            else if (stat_rd)
                rdata_reg <= {overrun_reg, 2'b00, 5'(count_reg)};
        end
    end

    // Storage carries no reset so it maps onto RAM; validity comes from count.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[tail_reg] <= rx_data;
    end

    assign rx_en = rx_en_reg;
    assign irq   = irq_reg;
    assign rdata = rdata_reg;
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-005 SHALL have port rx_end  input  1  receiver end flag, high for about one bit time per byte.
REQ-006 SHALL have port rx_en  output  1  receive enable to the UART receiver.
REQ-007 SHALL have port cs  input  1  CPU register access strobe, one cycle per access.
REQ-008 SHALL have port we  input  1  write (1) or read (0) qualifier for cs.
REQ-009 SHALL have port addr  input  1  register select: 0 = DATA, 1 = CTRL/STATUS.
REQ-010 SHALL have port wdata  input  8  write data.
REQ-011 SHALL have port rdata  output  8  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt request.

Function
REQ-013 SHALL hold a control register with bit0 = enable and bit1 = irq_en, written by cs&we&addr==1; wdata bit7 = 1 SHALL clear overrun in the same cycle.
REQ-014 SHALL drive rx_en = enable, registered; rx_en SHALL change in the cycle after the write.
REQ-015 SHALL run the capture FSM: IDLE, ARMED, PUSH, DRAIN.
REQ-016 SHALL use these transitions: IDLE->ARMED when enable=1; ARMED->PUSH on rising edge of rx_end (rx_end=1, previous-cycle rx_end=0); PUSH->DRAIN unconditionally after one cycle; DRAIN->ARMED when rx_end=0; any state->IDLE when enable=0.
REQ-017 SHALL sample rx_data into the FIFO tail in the PUSH state only, so each rx_end pulse produces exactly one push regardless of its length.
REQ-018 SHALL keep rx_end high at enable=1 from producing a push until rx_end has first been seen low.
REQ-019 SHALL maintain count of 0..DEPTH with wrapping head/tail pointers modulo DEPTH.
REQ-020 SHALL treat a DATA read (cs&~we&addr==0) as a pop: rdata <= head entry next cycle, head advances, count decrements.
REQ-021 SHALL, on a DATA read while empty, return rdata = 0x00 and leave the pointers and count unchanged.
REQ-022 SHALL, on a STATUS read, return rdata = {overrun, 2'b00, count[4:0]} with no side effect; count[4:0] is count zero-extended to 5 bits.
REQ-023 SHALL, when push and pop occur in the same cycle, perform both: count unchanged, popped data = the old head (including when full).
REQ-024 SHALL, on push while full without a simultaneous pop, drop the byte, leave the FIFO intact and set sticky overrun = 1.
REQ-025 SHALL, if overrun clear and a new overrun coincide, leave overrun = 1.
REQ-026 SHALL drive irq = irq_en & ((count != 0) | overrun), registered.
REQ-027 SHALL hold rdata unchanged on cycles without a read.
REQ-028 SHALL, when enable is cleared, retain FIFO contents and count; a byte whose rx_end rises in the same cycle SHALL be discarded.

Reset
REQ-029 SHALL, on rst_n=0 regardless of clk, set enable=0, irq_en=0, rx_en=0, overrun=0, count=0, head=tail=0, rdata=0x00, irq=0, FSM=IDLE, edge-detect history=0.
REQ-030 SHALL, on reset assertion mid-byte or mid-read, abandon the operation; after release the block SHALL idle until enable is written.

Verification
REQ-031 SHALL pass: write CTRL=0x03, pulse rx_end 434 cycles with rx_data=0xA5, read DATA -> rx_en=1 one cycle after the write; STATUS=0x01 and irq=1 after the push; DATA read returns 0xA5; then count=0 and irq=0.
REQ-032 SHALL pass: enable, push 0x11,0x22,0x33,0x44, then 0x55 -> STATUS=0x84; reads return 0x11..0x44; 0x55 lost; write CTRL=0x83 -> STATUS=0x00.
REQ-033 SHALL pass: FIFO full, rx_end edge coinciding with the PUSH-cycle DATA read -> read returns the oldest byte, new byte stored, count stays 4, overrun=0.
REQ-034 SHALL pass: DATA read while empty -> rdata=0x00, STATUS remains 0x00.
REQ-035 SHALL pass: rx_end held high 2000 cycles -> exactly one push; rx_end already high at enable -> no push.
REQ-036 SHALL pass: rst_n pulsed low mid-pulse with count=2 -> all outputs 0 asynchronously, STATUS=0x00 after release, rx_en stays 0.
